// File: rtl/fp_feed_pkg.sv
// Shared types and constants for the FP operand feeder and its operand classifier.
package fp_feed_pkg;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUBN,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_t;

  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         QNAN_BIT = 22;

endpackage

// File: rtl/fp_operand_feeder_classify.sv
// Combinational IEEE-754 binary32 class decoder used on each head-of-FIFO operand.
module fp_classify
  import fp_feed_pkg::*;
(
  input  logic [31:0] operand,
  output fp_class_t   cls
);

  logic [7:0]  exp_f;
  logic [22:0] mant_f;
  logic        unused_sign;

  assign exp_f       = operand[30:23];
  assign mant_f      = operand[22:0];
  // Sign does not affect the class; kept visible only to document that it is ignored.
  assign unused_sign = operand[31];

  always_comb begin
    cls = FP_NORM;
    if (exp_f == 8'h00) begin
      cls = (mant_f == 23'd0) ? FP_ZERO : FP_SUBN;
    end else if (exp_f == EXP_MAX) begin
      if (mant_f == 23'd0)          cls = FP_INF;
      else if (mant_f[QNAN_BIT])    cls = FP_QNAN;
      else                          cls = FP_SNAN;
    end
  end

endmodule

// File: rtl/fp_operand_feeder.sv
// Operand-pair FIFO in front of the FP multiplier: valid/ready on both sides,
// per-operand class tags on the head entry and a wrapping issued-pair counter.
module fp_operand_feeder
  import fp_feed_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [31:0]              s_a,
  input  logic [31:0]              s_b,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              m_a,
  output logic [31:0]              m_b,
  output fp_class_t                m_class_a,
  output fp_class_t                m_class_b,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         issued
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [31:0]      mem_a [DEPTH];
  logic [31:0]      mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [CNT_W-1:0] issued_q;
  logic             push;
  logic             pop;

  // Flow control depends on the registered level only, so no input-to-output paths.
  assign s_ready = (level_q != LVL_W'(DEPTH));
  assign m_valid = (level_q != '0);
  assign push    = s_valid && s_ready && !flush;
  assign pop     = m_valid && m_ready && !flush;

  assign level   = level_q;
  assign issued  = issued_q;
  assign m_a     = mem_a[rd_ptr];
  assign m_b     = mem_b[rd_ptr];

  // Storage: data path, no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= s_a;
      mem_b[wr_ptr] <= s_b;
    end
  end

  // Control: pointers, occupancy and issued counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      issued_q <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        issued_q <= issued_q + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  fp_classify u_cls_a (
    .operand (m_a),
    .cls     (m_class_a)
  );

  fp_classify u_cls_b (
    .operand (m_b),
    .cls     (m_class_b)
  );

endmodule

// File: tb/tb_fp_operand_feeder.sv
// Scoreboard bench for fp_operand_feeder: accepted pairs are queued with hand-derived
// class tags and compared against the head of the DUT at every pop.
module tb_fp_operand_feeder;
  import fp_feed_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    fp_class_t   ca;
    fp_class_t   cb;
  } pair_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_a;
  logic [31:0] m_b;
  fp_class_t   m_class_a;
  fp_class_t   m_class_b;
  logic [2:0]  level;
  logic [15:0] issued;

  fp_class_t   exp_ca;
  fp_class_t   exp_cb;
  pair_t       sb_q[$];
  int          n_vec;
  int          n_err;

  fp_operand_feeder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_class_a (m_class_a),
    .m_class_b (m_class_b),
    .level     (level),
    .issued    (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples mid-cycle, mirrors what the next rising edge will do.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else if (flush) begin
      sb_q.delete();
    end else begin
      if (m_valid && m_ready) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_underflow: DUT popped a=%h b=%h, scoreboard empty", m_a, m_b);
        end else begin
          pair_t e;
          e = sb_q.pop_front();
          if (m_a !== e.a || m_b !== e.b || m_class_a !== e.ca || m_class_b !== e.cb) begin
            n_err++;
            $display("FAIL pop_data: got a=%h b=%h ca=%0d cb=%0d, want a=%h b=%h ca=%0d cb=%0d",
                     m_a, m_b, m_class_a, m_class_b, e.a, e.b, e.ca, e.cb);
          end
        end
      end
      if (s_valid && s_ready) begin
        pair_t p;
        p.a  = s_a;
        p.b  = s_b;
        p.ca = exp_ca;
        p.cb = exp_cb;
        sb_q.push_back(p);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input fp_class_t ca, input fp_class_t cb);
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    exp_ca  = ca;
    exp_cb  = cb;
  endtask

  logic [31:0] va [6];
  fp_class_t   vc [6];
  logic [31:0] pa [4];
  logic [31:0] pb [4];
  fp_class_t   pca[4];
  fp_class_t   pcb[4];

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_a     = '0;
    s_b     = '0;
    exp_ca  = FP_ZERO;
    exp_cb  = FP_ZERO;

    pa = '{32'h3F800000, 32'h40400000, 32'hBFC00000, 32'h00000000};
    pb = '{32'h40000000, 32'h40800000, 32'h3F000000, 32'h40E00000};
    pca = '{FP_NORM, FP_NORM, FP_NORM, FP_ZERO};
    pcb = '{FP_NORM, FP_NORM, FP_NORM, FP_NORM};
    va = '{32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h80000000, 32'h7F800000, 32'h3F800000};
    vc = '{FP_QNAN, FP_SNAN, FP_SUBN, FP_ZERO, FP_INF, FP_NORM};

    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("reset_s_ready", s_ready, 1);
    check("reset_m_valid", m_valid, 0);
    check("reset_level", level, 0);
    check("reset_issued", issued, 0);

    // Fill to full with the multiplier stalled
    for (int i = 0; i < 4; i++) begin
      drive(pa[i], pb[i], pca[i], pcb[i]);
      tick();
      check("fill_level", level, i + 1);
    end
    s_valid = 1'b0;
    check("full_s_ready", s_ready, 0);
    check("full_m_valid", m_valid, 1);
    m_ready = 1'b1;
    tick();
    check("pop_frees_s_ready", s_ready, 1);
    check("after_first_pop_level", level, 3);
    repeat (3) tick();
    m_ready = 1'b0;
    check("drain_level", level, 0);
    check("drain_m_valid", m_valid, 0);
    check("drain_issued", issued, 4);

    // Sustained streaming
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(32'h3F800000 + i, 32'h00000001 + i, FP_NORM, FP_SUBN);
      tick();
      if (i > 0) check("stream_level", level, 1);
    end
    check("stream_issued", issued, 4 + 19);
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    check("stream_drain_level", level, 0);

    // Class tags on both operand ports
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(va[i], va[5 - i], vc[i], vc[5 - i]);
      tick();
    end
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    check("class_issued", issued, 30);

    // Flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(pa[i], pb[i], pca[i], pcb[i]);
      tick();
    end
    check("preflush_level", level, 3);
    drive(32'h12345678, 32'h9ABCDEF0, FP_NORM, FP_NORM);
    m_ready = 1'b1;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("flush_level", level, 0);
    check("flush_m_valid", m_valid, 0);
    check("flush_issued", issued, 30);

    // Same sequence with reset
    for (int i = 0; i < 3; i++) begin
      drive(pa[i], pb[i], pca[i], pcb[i]);
      tick();
    end
    check("prerst_level", level, 3);
    drive(32'h12345678, 32'h9ABCDEF0, FP_NORM, FP_NORM);
    m_ready = 1'b1;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("rst_level", level, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_issued", issued, 0);

    // Counter wrap: 65534 pops, then 3 more
    m_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive(32'h3F800000 + i, 32'h00000001 + i, FP_NORM, FP_SUBN);
      tick();
    end
    check("wrap_pre_issued", issued, 16'hFFFE);
    check("wrap_pre_level", level, 1);
    for (int i = 65535; i < 65538; i++) begin
      drive(32'h3F800000 + i, 32'h00000001 + i, FP_NORM, FP_SUBN);
      tick();
    end
    check("wrap_issued", issued, 16'h0001);
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    check("final_level", level, 0);
    check("final_scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
